sevenseg_mux: RTL
=================

Name: sevenseg_mux

Overview:
- Output-side counterpart to the board input conditioning: drives the Nexys4 8-digit common-anode seven-segment display from parallel per-digit codes.
- Time-multiplexes one digit at a time, with an all-off blanking gap between digits to suppress ghosting.
- Snapshots the inputs once per frame so a frame never shows a mix of old and new values.
- Sits between the CPU-side display registers and the board pins.

Parameters:
- CLK_FREQUENCY_HZ, 50_000000, input clock frequency.
- DIGIT_FREQUENCY_HZ, 4000, digit-advance rate; frame rate is this divided by 8.
- BLANK_CYCLES, 16, clocks with all anodes off between digits; must be less than top_cnt.
- CNTR_WIDTH, 32, width of the refresh counter.
- SIMULATE, 0, when 1, use the short count below.
- SIMULATE_FREQUENCY_CNT, 5, top_cnt when SIMULATE=1; effective blank is then 1 clock.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- digits_in  input  40  8 x 5-bit codes; digit i = [5i+4:5i]; bit4=1 blanks the digit, bits3:0 = hex value
- dp_in  input  8  decimal point per digit, 1 = lit
- an_out  output  8  anodes, active low, an_out[i] = digit i
- seg_out  output  7  cathodes, active low; [0]=CA ... [6]=CG
- dp_out  output  1  decimal-point cathode, active low
- frame_tick  output  1  one-clock pulse when a new snapshot is taken

Behaviour:
- All outputs are registered. Reset values: an_out=8'hFF, seg_out=7'h7F, dp_out=1, frame_tick=0.
- Reset also sets: digit index=0, state=S_BLANK, blank counter=0, snapshot = all digits blanked with dp off.
- Refresh counter:
  - top_cnt = SIMULATE ? SIMULATE_FREQUENCY_CNT : CLK/DIGIT_FREQ-1.
  - Free-running; wraps to 0 at top_cnt and asserts tick for that one cycle.
- FSM S_BLANK:
  - an_out=8'hFF, seg_out=7'h7F, dp_out=1.
  - The blank counter increments each clock.
  - When it reaches the effective blank count, go to S_ON.
  - If the new index is 0 on that exit, capture digits_in/dp_in into the snapshot and pulse frame_tick in the same cycle.
- FSM S_ON:
  - an_out has only bit [index] low; seg_out = decode(snapshot[index]); dp_out = ~snap_dp[index].
  - The first S_ON cycle displays the freshly captured snapshot.
  - On tick: go to S_BLANK, clear the blank counter, index = index+1 mod 8 (7 wraps to 0).
- A tick that arrives during S_BLANK is ignored. The parameter constraint prevents this; a violation simply drops that tick.
- Input changes between snapshots have no visible effect until the next frame_tick.
- Reset asserted mid-digit forces all outputs to their reset values asynchronously. After release, digit 0 is displayed after exactly the effective blank count.
- Decode values (active low):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
  - blank bit set = 7'h7F (dp is still honoured)

Optional Feature:
- Macro: SEVENSEG_DIM_EN.
- Defined:
  - Adds input brightness [2:0].
  - A 3-bit PWM counter free-runs each clock.
  - In S_ON, the active anode is low only when pwm_cnt <= brightness; otherwise an_out=8'hFF.
  - brightness=7 gives full duty; 0 gives 1/8 duty.
  - brightness is sampled at the snapshot like digits_in.
  - PWM counter resets to 0.
- Undefined: port absent; full duty in S_ON.

Decomposition:
- Shared package holds:
  - SEG7_BLANK = 7'h7F and the 16-entry hex segment constant table.
  - Digit code width (5) and digit count (8).
  - State encoding S_BLANK/S_ON.
- One natural sub-module: hex_to_seg7, a pure combinational 5-bit code to 7-bit active-low segments decoder. It is reused by other display paths.

Test Plan:
All cases use SIMULATE=1, so tick every 6 clocks and blank = 1 clock.
- Reset release with digits_in=all 8'h0 codes (value 0, not blank): after 1 clock, frame_tick=1, an_out=8'hFE, seg_out=7'h40. Digit 0 holds 5 clocks, then 1 clock of an_out=8'hFF, then an_out=8'hFD.
- digits_in = hex 0..7 on digits 0..7, dp_in=8'h01: over one 48-clock frame, seg_out sequence is 40,79,24,30,19,12,02,78. dp_out=0 only while an_out=8'hFE. frame_tick repeats every 48 clocks.
- Change digits_in mid-frame (digit 3 active) from 8 to F: displayed digit 3 stays 7'h00 until after the next frame_tick, then shows 7'h0E.
- Blank bit set on digit 5 with dp_in[5]=1: while an_out=8'hDF, seg_out=7'h7F and dp_out=0.
- Assert reset while digit 6 is active: an_out=8'hFF, seg_out=7'h7F the same cycle without a clock edge. Restart shows digit 0 with a blanked-snapshot overwritten by the current inputs.
- SEVENSEG_DIM_EN with brightness=3: during S_ON the active anode is low for 4 of every 8 clocks. brightness=7 gives continuous low.

Source files
------------

// File: rtl/sevenseg_mux_pkg.sv
// rtl/sevenseg_mux_pkg.sv - shared constants, segment table and state encoding for the display mux
package sevenseg_mux_pkg;

  localparam int DIGIT_W    = 5;
  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  // Active-low CA..CG patterns, entry 0 in the low bits
  localparam logic [15:0][6:0] SEG7_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } state_t;

endpackage

// File: rtl/sevenseg_mux_if.sv
// rtl/sevenseg_mux_if.sv - display code inputs and board pin outputs; brightness present with SEVENSEG_DIM_EN
interface sevenseg_mux_if;
  import sevenseg_mux_pkg::*;

  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in;
  logic [NUM_DIGITS-1:0]         dp_in;
`ifdef SEVENSEG_DIM_EN
  logic [2:0]                    brightness;
`endif
  logic [NUM_DIGITS-1:0]         an_out;
  logic [6:0]                    seg_out;
  logic                          dp_out;
  logic                          frame_tick;

`ifdef SEVENSEG_DIM_EN
  modport master (output digits_in, dp_in, brightness,
                  input  an_out, seg_out, dp_out, frame_tick);
  modport slave  (input  digits_in, dp_in, brightness,
                  output an_out, seg_out, dp_out, frame_tick);
`else
  modport master (output digits_in, dp_in,
                  input  an_out, seg_out, dp_out, frame_tick);
  modport slave  (input  digits_in, dp_in,
                  output an_out, seg_out, dp_out, frame_tick);
`endif

endinterface

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - 5-bit digit code to active-low seven-segment pattern, bit 4 blanks
module hex_to_seg7
  import sevenseg_mux_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [6:0]         seg
);

  assign seg = code[4] ? SEG7_BLANK : SEG7_HEX[code[3:0]];

endmodule

// File: rtl/sevenseg_mux.sv
// rtl/sevenseg_mux.sv - 8-digit multiplexed seven-segment driver with per-frame snapshot; SEVENSEG_DIM_EN adds PWM dimming
module sevenseg_mux
  import sevenseg_mux_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ       = 50_000_000,
  parameter int DIGIT_FREQUENCY_HZ     = 4000,
  parameter int BLANK_CYCLES           = 16,
  parameter int CNTR_WIDTH             = 32,
  parameter int SIMULATE               = 0,
  parameter int SIMULATE_FREQUENCY_CNT = 5
) (
  input  logic          clk,
  input  logic          reset,
  sevenseg_mux_if.slave bus
);

  localparam logic [CNTR_WIDTH-1:0] TOP_CNT = CNTR_WIDTH'((SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                                          : CLK_FREQUENCY_HZ / DIGIT_FREQUENCY_HZ - 1);
  localparam logic [CNTR_WIDTH-1:0] BLANK_TOP = CNTR_WIDTH'((SIMULATE != 0) ? 1 : BLANK_CYCLES);

  logic [CNTR_WIDTH-1:0] refresh_cnt;
  logic                  tick;

  state_t                state, state_nxt;
  logic [2:0]            idx, idx_nxt;
  logic [CNTR_WIDTH-1:0] blank_cnt, blank_nxt;
  logic                  capture;

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] snap_dig, snap_dig_nxt;
  logic [NUM_DIGITS-1:0]              snap_dp, snap_dp_nxt;

  logic [DIGIT_W-1:0]    code_nxt;
  logic [6:0]            seg_dec;
  logic                  duty_on;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  assign tick = (refresh_cnt == TOP_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
    end else if (tick) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + CNTR_WIDTH'(1);
    end
  end

  // A tick landing in S_BLANK is dropped on purpose; the digit just stays blank longer
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    blank_nxt = blank_cnt;
    capture   = 1'b0;
    case (state)
      S_BLANK: begin
        blank_nxt = blank_cnt + CNTR_WIDTH'(1);
        if (blank_nxt == BLANK_TOP) begin
          state_nxt = S_ON;
          capture   = (idx == 3'd0);
        end
      end
      S_ON: begin
        if (tick) begin
          state_nxt = S_BLANK;
          blank_nxt = '0;
          idx_nxt   = idx + 3'd1;
        end
      end
    endcase
  end

  assign snap_dig_nxt = capture ? bus.digits_in : snap_dig;
  assign snap_dp_nxt  = capture ? bus.dp_in     : snap_dp;

  // Outputs are built from next-cycle values so the first lit cycle shows the fresh snapshot
  assign code_nxt = snap_dig_nxt[idx_nxt];

  hex_to_seg7 u_dec (
    .code (code_nxt),
    .seg  (seg_dec)
  );

`ifdef SEVENSEG_DIM_EN
  logic [2:0] pwm_cnt, pwm_nxt;
  logic [2:0] snap_br, snap_br_nxt;

  assign pwm_nxt     = pwm_cnt + 3'd1;
  assign snap_br_nxt = capture ? bus.brightness : snap_br;
  assign duty_on     = (pwm_nxt <= snap_br_nxt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= 3'd0;
      snap_br <= 3'd7;
    end else begin
      pwm_cnt <= pwm_nxt;
      snap_br <= snap_br_nxt;
    end
  end
`else
  assign duty_on = 1'b1;
`endif

  assign an_nxt  = (state_nxt == S_ON && duty_on) ? ~(8'b1 << idx_nxt) : 8'hFF;
  assign seg_nxt = (state_nxt == S_ON) ? seg_dec : SEG7_BLANK;
  assign dp_nxt  = (state_nxt == S_ON) ? ~snap_dp_nxt[idx_nxt] : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_BLANK;
      idx            <= 3'd0;
      blank_cnt      <= '0;
      snap_dig       <= {NUM_DIGITS{5'h10}};
      snap_dp        <= '0;
      bus.an_out     <= 8'hFF;
      bus.seg_out    <= SEG7_BLANK;
      bus.dp_out     <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      blank_cnt      <= blank_nxt;
      snap_dig       <= snap_dig_nxt;
      snap_dp        <= snap_dp_nxt;
      bus.an_out     <= an_nxt;
      bus.seg_out    <= seg_nxt;
      bus.dp_out     <= dp_nxt;
      bus.frame_tick <= capture;
    end
  end

endmodule
